uart_tx_arbiter: RTL and testbench

- Shares the single UART TX byte stream between NUM_REQ independent requesters (PE cores), replacing the bitwise-OR merge of per-PE write strobes.
- Each requester gets a private byte FIFO.
- A round-robin scheduler grants the TX path to one requester per text line, so lines from different PEs never interleave.
- Sits between the PE write ports and the UART controller's tx_fifo write port, in the i_clk domain.

---
 rtl/uart_arb_pkg.sv | 18 +
 rtl/uart_arb_fifo.sv | 49 ++++
 rtl/uart_tx_arbiter.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and byte constants for the UART TX line arbiter.
package uart_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TAG0,
        TAG1,
        TAG2,
        SEND,
        RELEASE
    } arb_state_t;

    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_LBR  = 8'h5B;
    localparam logic [7:0] ASCII_RBR  = 8'h5D;
    localparam logic [7:0] ASCII_ZERO = 8'h30;

endpackage

// File: rtl/uart_arb_fifo.sv
// Per-requester byte FIFO with show-ahead read data and a registered full flag.
module uart_arb_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_wren,
    input  logic [7:0] i_wdata,
    input  logic       i_pop,
    output logic [7:0] o_dout,
    output logic       o_empty,
    output logic       o_full,
    output logic       o_drop
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wptr, rptr;
    logic [AW:0] wptr_nxt, rptr_nxt;
    logic        wr_ok, rd_ok;

    assign o_empty  = (wptr == rptr);
    assign o_dout   = mem[rptr[AW-1:0]];
    assign rd_ok    = i_pop && !o_empty;
    // A pop in the same cycle frees the slot, so a write to a full FIFO still lands.
    assign wr_ok    = i_wren && (!o_full || rd_ok);
    assign o_drop   = i_wren && !wr_ok;
    assign wptr_nxt = wptr + {{AW{1'b0}}, wr_ok};
    assign rptr_nxt = rptr + {{AW{1'b0}}, rd_ok};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr   <= '0;
            rptr   <= '0;
            o_full <= 1'b0;
        end else begin
            wptr   <= wptr_nxt;
            rptr   <= rptr_nxt;
            o_full <= ((wptr_nxt - rptr_nxt) == DEPTH_CNT);
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_ok) mem[wptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Line-granular round-robin arbiter merging NUM_REQ byte streams onto one UART TX port.
// Define UART_ARB_TAG_EN to prefix every granted line with "[k]".
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned LOCK_TIMEOUT = 1024
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [NUM_REQ-1:0]   i_req_wren,
    input  logic [NUM_REQ*8-1:0] i_req_wdata,
    output logic [NUM_REQ-1:0]   o_req_full,
    output logic                 o_tx_valid,
    output logic [7:0]           o_tx_data,
    input  logic                 i_tx_ready,
    output logic [NUM_REQ-1:0]   o_grant,
    output logic                 o_drop_pulse
);

    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CW = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(LOCK_TIMEOUT);

    arb_state_t         state, state_nxt;
    logic [IW-1:0]      gidx, gidx_nxt;
    logic [IW-1:0]      rr, rr_nxt;
    logic [IW-1:0]      cand, hit_idx;
    logic               hit;
    logic [CW-1:0]      idle_cnt;
    logic [NUM_REQ-1:0] fifo_empty, drop_vec, pop_vec;
    logic [7:0]         fifo_dout [NUM_REQ];
    logic               out_free, cur_empty, send_pop, load;
    logic [7:0]         cur_dout, load_data;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_fifo
        uart_arb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_wren  (i_req_wren[k]),
            .i_wdata (i_req_wdata[8*k +: 8]),
            .i_pop   (pop_vec[k]),
            .o_dout  (fifo_dout[k]),
            .o_empty (fifo_empty[k]),
            .o_full  (o_req_full[k]),
            .o_drop  (drop_vec[k])
        );
    end

    // The output register can take a byte when empty or when its byte leaves this cycle.
    assign out_free  = !o_tx_valid || i_tx_ready;
    assign cur_empty = fifo_empty[gidx];
    assign cur_dout  = fifo_dout[gidx];
    assign send_pop  = (state == SEND) && !cur_empty && out_free;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            gidx  <= '0;
            rr    <= '0;
        end else begin
            state <= state_nxt;
            gidx  <= gidx_nxt;
            rr    <= rr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gidx_nxt  = gidx;
        rr_nxt    = rr;
        hit       = 1'b0;
        hit_idx   = rr;
        cand      = rr;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = IW'((32'(rr) + i) % NUM_REQ);
            if (!hit && !fifo_empty[cand]) begin
                hit     = 1'b1;
                hit_idx = cand;
            end
        end
        case (state)
            IDLE: begin
                if (hit) begin
                    gidx_nxt = hit_idx;
`ifdef UART_ARB_TAG_EN
                    state_nxt = TAG0;
`else
                    state_nxt = SEND;
`endif
                end
            end
`ifdef UART_ARB_TAG_EN
            TAG0: if (out_free) state_nxt = TAG1;
            TAG1: if (out_free) state_nxt = TAG2;
            TAG2: if (out_free) state_nxt = SEND;
`endif
            SEND: begin
                if (send_pop && cur_dout == ASCII_LF)
                    state_nxt = RELEASE;
                else if (cur_empty && idle_cnt == CNT_LAST)
                    state_nxt = RELEASE;
            end
            RELEASE: begin
                rr_nxt    = (32'(gidx) == NUM_REQ - 1) ? '0 : gidx + IW'(1);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load      = 1'b0;
        load_data = cur_dout;
        pop_vec   = '0;
        o_grant   = '0;
        case (state)
`ifdef UART_ARB_TAG_EN
            TAG0: begin
                load      = out_free;
                load_data = ASCII_LBR;
            end
            TAG1: begin
                load      = out_free;
                load_data = ASCII_ZERO + 8'(gidx);
            end
            TAG2: begin
                load      = out_free;
                load_data = ASCII_RBR;
            end
`endif
            SEND: begin
                load          = send_pop;
                pop_vec[gidx] = send_pop;
            end
            default: load = 1'b0;
        endcase
        if (state inside {TAG0, TAG1, TAG2, SEND}) o_grant[gidx] = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            idle_cnt     <= '0;
            o_tx_valid   <= 1'b0;
            o_tx_data    <= '0;
            o_drop_pulse <= 1'b0;
        end else begin
            if (state != SEND || send_pop)
                idle_cnt <= '0;
            else if (cur_empty && idle_cnt != CNT_MAX)
                idle_cnt <= idle_cnt + CW'(1);
            if (load) begin
                o_tx_valid <= 1'b1;
                o_tx_data  <= load_data;
            end else if (i_tx_ready) begin
                o_tx_valid <= 1'b0;
            end
            o_drop_pulse <= |drop_vec;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter; expected streams come from a line-level round-robin model.
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int FD = 16;
    localparam int LT = 64;
`ifdef UART_ARB_TAG_EN
    localparam int TAGLEN = 3;
`else
    localparam int TAGLEN = 0;
`endif

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR-1:0]   wren  = '0;
    logic [NR*8-1:0] wdata = '0;
    logic [NR-1:0]   full;
    logic            valid;
    logic [7:0]      data;
    logic            ready = 1'b0;
    logic [NR-1:0]   grant;
    logic            drop;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    logic [7:0] strm [NR][$];

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(NR), .FIFO_DEPTH(FD), .LOCK_TIMEOUT(LT)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_wren   (wren),
        .i_req_wdata  (wdata),
        .o_req_full   (full),
        .o_tx_valid   (valid),
        .o_tx_data    (data),
        .i_tx_ready   (ready),
        .o_grant      (grant),
        .o_drop_pulse (drop)
    );

    always @(negedge clk)
        if (rst_n && valid && ready) got.push_back(data);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wren  = '0;
        wdata = '0;
        ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        got.delete();
        exp_q.delete();
    endtask

    function automatic void add_tag(input int k);
        if (TAGLEN > 0) begin
            exp_q.push_back(8'h5B);
            exp_q.push_back(8'h30 + 8'(k));
            exp_q.push_back(8'h5D);
        end
    endfunction

    task automatic put(input int k, input logic [7:0] b);
        wren = '0;
        wren[k] = 1'b1;
        wdata[8*k +: 8] = b;
        tick();
        wren = '0;
    endtask

    task automatic test_reset();
        do_reset();
        checks += 5;
        if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", valid); end
        if (data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h want=00", data); end
        if (grant !== '0) begin failures++; $display("FAIL reset_grant got=%b want=0000", grant); end
        if (drop !== 1'b0) begin failures++; $display("FAIL reset_drop got=%b want=0", drop); end
        if (full !== '0) begin failures++; $display("FAIL reset_full got=%b want=0000", full); end
    endtask

    task automatic test_single_line();
        do_reset();
        ready = 1'b1;
        add_tag(0);
        exp_q.push_back(8'h68); exp_q.push_back(8'h69); exp_q.push_back(8'h0A);
        wren[0] = 1'b1; wdata[7:0] = 8'h68;
        tick();
        checks++;
        if (valid !== 1'b0) begin failures++; $display("FAIL single_early1 valid=%b want=0", valid); end
        wdata[7:0] = 8'h69;
        tick();
        checks += 2;
        if (valid !== 1'b0) begin failures++; $display("FAIL single_early2 valid=%b want=0", valid); end
        if (grant !== 4'b0001) begin failures++; $display("FAIL single_grant got=%b want=0001", grant); end
        wdata[7:0] = 8'h0A;
        tick();
        wren = '0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) tick();
            checks++;
            if (valid !== 1'b1 || data !== exp_q[i]) begin
                failures++;
                $display("FAIL single_cycle[%0d] valid=%b data=%h want valid=1 data=%h", i, valid, data, exp_q[i]);
            end
        end
        tick();
        tick();
        checks++;
        if (grant !== 4'b0000) begin failures++; $display("FAIL single_release got=%b want=0000", grant); end
        checks++;
        if (got.size() !== exp_q.size()) begin
            failures++; $display("FAIL single_len got=%0d want=%0d", got.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++;
            if (got[i] !== exp_q[i]) begin failures++; $display("FAIL single_byte[%0d] got=%h want=%h", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_interleave();
        do_reset();
        ready = 1'b1;
        add_tag(0); exp_q.push_back(8'h41); exp_q.push_back(8'h41); exp_q.push_back(8'h0A);
        add_tag(1); exp_q.push_back(8'h42); exp_q.push_back(8'h42); exp_q.push_back(8'h0A);
        for (int i = 0; i < 3; i++) begin
            wren = 4'b0011;
            wdata[7:0]  = (i == 2) ? 8'h0A : 8'h41;
            wdata[15:8] = (i == 2) ? 8'h0A : 8'h42;
            tick();
        end
        wren = '0;
        for (int n = 0; n < 200 && got.size() < exp_q.size(); n++) tick();
        checks++;
        if (got.size() !== exp_q.size()) begin
            failures++; $display("FAIL interleave_len got=%0d want=%0d", got.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++;
            if (got[i] !== exp_q[i]) begin failures++; $display("FAIL interleave_byte[%0d] got=%h want=%h", i, got[i], exp_q[i]); end
        end
        // pointer should now sit at 2: req2 must beat req0 when both arrive together
        tick(); tick(); tick();
        got.delete();
        exp_q.delete();
        add_tag(2); exp_q.push_back(8'h0A);
        add_tag(0); exp_q.push_back(8'h0A);
        wren = 4'b0101;
        wdata[7:0] = 8'h0A; wdata[23:16] = 8'h0A;
        tick();
        wren = '0;
        for (int n = 0; n < 200 && got.size() < exp_q.size(); n++) tick();
        checks++;
        if (got.size() !== exp_q.size()) begin
            failures++; $display("FAIL rr_len got=%0d want=%0d", got.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++;
            if (got[i] !== exp_q[i]) begin failures++; $display("FAIL rr_byte[%0d] got=%h want=%h", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_backpressure();
        int n;
        do_reset();
        ready = 1'b1;
        add_tag(0);
        exp_q.push_back(8'h68); exp_q.push_back(8'h69); exp_q.push_back(8'h0A);
        put(0, 8'h68); put(0, 8'h69); put(0, 8'h0A);
        for (n = 0; n < 20 && !(valid === 1'b1 && data === 8'h69); n++) tick();
        ready = 1'b0;
        checks++;
        if (!(valid === 1'b1 && data === 8'h69)) begin
            failures++; $display("FAIL bp_reach valid=%b data=%h want 1/69", valid, data);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (valid !== 1'b1 || data !== 8'h69) begin
                failures++; $display("FAIL bp_hold[%0d] valid=%b data=%h want 1/69", i, valid, data);
            end
        end
        ready = 1'b1;
        tick();
        checks++;
        if (valid !== 1'b1 || data !== 8'h0A) begin
            failures++; $display("FAIL bp_resume valid=%b data=%h want 1/0a", valid, data);
        end
        tick(); tick();
        checks++;
        if (got.size() !== exp_q.size()) begin
            failures++; $display("FAIL bp_len got=%0d want=%0d", got.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++;
            if (got[i] !== exp_q[i]) begin failures++; $display("FAIL bp_byte[%0d] got=%h want=%h", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_overflow();
        int drops;
        logic [7:0] b;
        do_reset();
        ready = 1'b0;
        add_tag(0); exp_q.push_back(8'h71);
        add_tag(2);
        put(0, 8'h71);
        for (int n = 0; n < 20 && valid !== 1'b1; n++) tick();
        checks++;
        if (valid !== 1'b1) begin failures++; $display("FAIL ovf_hold valid=%b want=1", valid); end
        drops = 0;
        for (int i = 0; i < FD + 1; i++) begin
            b = 8'($urandom_range(32, 126));
            if (i < FD) exp_q.push_back(b);
            wren = 4'b0100;
            wdata[23:16] = b;
            tick();
            if (drop === 1'b1) drops++;
            if (i == FD - 2) begin
                checks++;
                if (full[2] !== 1'b0) begin failures++; $display("FAIL ovf_full_early got=%b want=0", full[2]); end
            end
            if (i == FD - 1) begin
                checks++;
                if (full[2] !== 1'b1) begin failures++; $display("FAIL ovf_full got=%b want=1", full[2]); end
            end
        end
        wren = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (drop === 1'b1) drops++;
        end
        checks++;
        if (drops != 1) begin failures++; $display("FAIL ovf_drop_pulses got=%0d want=1", drops); end
        ready = 1'b1;
        for (int n = 0; n < 6 * LT && got.size() < exp_q.size(); n++) tick();
        tick(); tick();
        checks++;
        if (got.size() !== exp_q.size()) begin
            failures++; $display("FAIL ovf_len got=%0d want=%0d", got.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++;
            if (got[i] !== exp_q[i]) begin failures++; $display("FAIL ovf_byte[%0d] got=%h want=%h", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_timeout();
        int held;
        logic moved;
        do_reset();
        ready = 1'b1;
        add_tag(3); exp_q.push_back(8'h78);
        add_tag(0); exp_q.push_back(8'h79); exp_q.push_back(8'h0A);
        put(3, 8'h78);
        held  = 0;
        moved = 1'b0;
        for (int n = 0; n < 4 * LT && !moved; n++) begin
            if (grant === 4'b1000) held++;
            if (grant === 4'b0001) moved = 1'b1;
            wren = '0;
            if (n == 2) begin wren[0] = 1'b1; wdata[7:0] = 8'h79; end
            if (n == 3) begin wren[0] = 1'b1; wdata[7:0] = 8'h0A; end
            tick();
        end
        wren = '0;
        checks += 2;
        if (!moved) begin failures++; $display("FAIL timeout_move grant=%b want=0001", grant); end
        if (held < LT || held > LT + TAGLEN + 2) begin
            failures++; $display("FAIL timeout_hold cycles=%0d want=%0d..%0d", held, LT, LT + TAGLEN + 2);
        end
        for (int n = 0; n < 50 && got.size() < exp_q.size(); n++) tick();
        checks++;
        if (got.size() !== exp_q.size()) begin
            failures++; $display("FAIL timeout_len got=%0d want=%0d", got.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++;
            if (got[i] !== exp_q[i]) begin failures++; $display("FAIL timeout_byte[%0d] got=%h want=%h", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        int lines, nl, len, k, rr;
        int pos [NR];
        logic hold;
        logic [7:0] hold_data;
        do_reset();
        lines = 0;
        for (int r = 0; r < NR; r++) begin
            strm[r].delete();
            pos[r] = 0;
            nl = $urandom_range(0, 3);
            for (int l = 0; l < nl; l++) begin
                len = $urandom_range(1, 4);
                for (int b = 0; b < len; b++) strm[r].push_back(8'($urandom_range(32, 126)));
                strm[r].push_back(8'h0A);
            end
            lines += nl;
        end
        if (lines == 0) begin strm[0].push_back(8'h0A); lines = 1; end
        // whole lines leave in round-robin order starting from requester 0
        rr = 0;
        while (lines > 0) begin
            k = rr;
            while (pos[k] >= strm[k].size()) k = (k + 1) % NR;
            add_tag(k);
            do begin
                exp_q.push_back(strm[k][pos[k]]);
                pos[k]++;
            end while (strm[k][pos[k] - 1] != 8'h0A);
            rr = (k + 1) % NR;
            lines--;
        end
        hold = 1'b0;
        hold_data = '0;
        for (int t = 0; t < 3000; t++) begin
            if (t >= FD && got.size() >= exp_q.size()) break;
            wren = '0;
            for (int r = 0; r < NR; r++)
                if (t < strm[r].size()) begin
                    wren[r] = 1'b1;
                    wdata[8*r +: 8] = strm[r][t];
                end
            ready = ($urandom_range(0, 9) < 7);
            hold = (valid === 1'b1) && !ready;
            hold_data = data;
            tick();
            if (hold) begin
                checks++;
                if (valid !== 1'b1 || data !== hold_data) begin
                    failures++; $display("FAIL rand_stable t=%0d valid=%b data=%h want 1/%h", t, valid, data, hold_data);
                end
            end
        end
        wren  = '0;
        ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (got.size() !== exp_q.size()) begin
            failures++; $display("FAIL rand_len got=%0d want=%0d", got.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++;
            if (got[i] !== exp_q[i]) begin failures++; $display("FAIL rand_byte[%0d] got=%h want=%h", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_midline();
        do_reset();
        ready = 1'b0;
        put(1, 8'h61); put(1, 8'h62); put(1, 8'h63);
        for (int n = 0; n < 20 && valid !== 1'b1; n++) tick();
        checks++;
        if (valid !== 1'b1) begin failures++; $display("FAIL rstmid_pre valid=%b want=1", valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b want=0", valid); end
        if (grant !== '0) begin failures++; $display("FAIL rstmid_grant got=%b want=0000", grant); end
        if (data !== 8'h00) begin failures++; $display("FAIL rstmid_data got=%h want=00", data); end
        tick();
        rst_n = 1'b1;
        ready = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        checks += 3;
        if (got.size() != 0) begin failures++; $display("FAIL rstmid_flush got=%0d bytes want=0", got.size()); end
        if (grant !== '0) begin failures++; $display("FAIL rstmid_idle grant=%b want=0000", grant); end
        if (full !== '0) begin failures++; $display("FAIL rstmid_full got=%b want=0000", full); end
    endtask

    initial begin
        test_reset();
        test_single_line();
        test_interleave();
        test_backpressure();
        test_overflow();
        test_timeout();
        for (int it = 0; it < 4; it++) test_random();
        test_reset_midline();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
